minterm_lut: RTL and testbench

Parametrised, programmable sum-of-minterms function unit: an N_IN-input, N_OUT-output truth table held in registers, reloadable at run time through a write port. It evaluates presented inputs with a registered one-cycle result, and can self-sweep all 2^N_IN input codes, streaming every result and counting the on-set of output 0. It replaces hand-wired single-function gate networks. Its reset table reproduces the team's fixed function Σm(4,5,6,7,11,12,13).

---
 rtl/minterm_pkg.sv | 24 ++
 rtl/minterm_table.sv | 36 +++
 rtl/minterm_lut.sv | 134 +++++++++++++
 tb/tb_minterm_lut.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// Shared types and helpers for the programmable sum-of-minterms unit.
package minterm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int MAX_D    = 256;
   localparam int MAX_BITS = 1024;

   // Column of the flat INIT vector that belongs to output o (bit m = minterm m).
   function automatic logic [MAX_D-1:0] init_col(input logic [MAX_BITS-1:0] init,
                                                 input int d, input int o);
      logic [MAX_D-1:0] col;
      col = '0;
      for (int m = 0; m < d; m++) begin
         col[m] = init[o*d+m];
      end
      return col;
   endfunction

endpackage

// File: rtl/minterm_table.sv
// D x N_OUT truth-table storage: async INIT load, one write port, combinational read.
module minterm_table
   import minterm_pkg::*;
#(
   parameter int                         N_IN  = 4,
   parameter int                         N_OUT = 1,
   parameter logic [N_OUT*(2**N_IN)-1:0] INIT  = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [N_IN-1:0]  waddr_i,
   input  logic [N_OUT-1:0] wdata_i,
   input  logic [N_IN-1:0]  raddr_i,
   output logic [N_OUT-1:0] rdata_o
);

   localparam int                    D        = 2**N_IN;
   localparam logic [MAX_BITS-1:0]   INIT_EXT = MAX_BITS'(INIT);

   for (genvar o = 0; o < N_OUT; o++) begin : g_col
      localparam logic [MAX_D-1:0] COL = init_col(INIT_EXT, D, o);
      logic [D-1:0] col_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            col_q <= COL[D-1:0];
         end else if (we_i) begin
            col_q[waddr_i] <= wdata_i[o];
         end
      end

      assign rdata_o[o] = col_q[raddr_i];
   end

endmodule

// File: rtl/minterm_lut.sv
// Programmable N_IN-in / N_OUT-out sum-of-minterms unit with single evaluate and
// full-table sweep; reset table reproduces sum m(4,5,6,7,11,12,13).
module minterm_lut
   import minterm_pkg::*;
#(
   parameter int                         N_IN  = 4,
   parameter int                         N_OUT = 1,
   parameter logic [N_OUT*(2**N_IN)-1:0] INIT  = 'h38F0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [N_IN-1:0]  cfg_addr,
   input  logic [N_OUT-1:0] cfg_data,
   output logic             cfg_err,
   input  logic             eval_valid,
   input  logic [N_IN-1:0]  eval_in,
   output logic             eval_ready,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic [N_IN:0]    sweep_ones,
   output logic             out_valid,
   output logic [N_IN-1:0]  out_idx,
   output logic [N_OUT-1:0] out_y
);

   localparam int              D        = 2**N_IN;
   localparam logic [N_IN-1:0] IDX_LAST = N_IN'(D-1);

   state_e            state_q;
   logic [N_IN-1:0]   idx_q;
   logic              last_q;
   logic              busy_q;
   logic              done_q;
   logic              cfg_err_q;
   logic [N_IN:0]     ones_q;
   logic [N_IN:0]     ones_d;
   logic              out_valid_q;
   logic [N_IN-1:0]   out_idx_q;
   logic [N_OUT-1:0]  out_y_q;

   logic              in_idle;
   logic              eval_fire;
   logic              sweep_fire;
   logic              wr_en;
   logic [N_IN-1:0]   rd_addr;
   logic [N_OUT-1:0]  rd_data;

   assign in_idle    = (state_q == IDLE);
   assign eval_fire  = in_idle && eval_valid;
   // last_q marks the drain cycle after index D-1 has been issued; nothing is read then.
   assign sweep_fire = (state_q == SWEEP) && !last_q;
   assign wr_en      = in_idle && cfg_we;
   assign rd_addr    = (state_q == SWEEP) ? idx_q : eval_in;
   assign ones_d     = ones_q + (N_IN+1)'(rd_data[0]);

   minterm_table #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .INIT  (INIT)
   ) u_table (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .we_i    (wr_en),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         ones_q      <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_y_q     <= '0;
      end else begin
         out_valid_q <= eval_fire || sweep_fire;
         if (eval_fire || sweep_fire) begin
            out_y_q   <= rd_data;
            out_idx_q <= rd_addr;
         end
         cfg_err_q <= cfg_we && !in_idle;
         done_q    <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (sweep_start) begin
                  state_q <= SWEEP;
                  idx_q   <= '0;
                  last_q  <= 1'b0;
                  ones_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SWEEP: begin
               if (last_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  ones_q <= ones_d;
                  if (idx_q == IDX_LAST) begin
                     last_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + N_IN'(1);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign eval_ready = in_idle;
   assign sweep_busy = busy_q;
   assign sweep_done = done_q;
   assign sweep_ones = ones_q;
   assign cfg_err    = cfg_err_q;
   assign out_valid  = out_valid_q;
   assign out_idx    = out_idx_q;
   assign out_y      = out_y_q;

endmodule

// File: tb/tb_minterm_lut.sv
// Randomised and directed bench for minterm_lut against a truth-table reference model.
module tb_minterm_lut;

   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   // default configuration: N_IN=4, N_OUT=1
   logic       cfg_we, cfg_err, eval_valid, eval_ready;
   logic [3:0] cfg_addr, eval_in, out_idx;
   logic [0:0] cfg_data, out_y;
   logic       sweep_start, sweep_busy, sweep_done, out_valid;
   logic [4:0] sweep_ones;

   // second configuration: N_IN=3, N_OUT=2
   logic       cfg_we3, cfg_err3, eval_valid3, eval_ready3;
   logic [2:0] cfg_addr3, eval_in3, out_idx3;
   logic [1:0] cfg_data3, out_y3;
   logic       sweep_start3, sweep_busy3, sweep_done3, out_valid3;
   logic [3:0] sweep_ones3;

   int n_checks = 0;
   int n_errors = 0;
   bit ref_tab [16];

   minterm_lut dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
      .eval_valid(eval_valid), .eval_in(eval_in), .eval_ready(eval_ready),
      .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
      .sweep_ones(sweep_ones), .out_valid(out_valid), .out_idx(out_idx), .out_y(out_y)
   );

   minterm_lut #(.N_IN(3), .N_OUT(2), .INIT(16'h0F96)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_data(cfg_data3), .cfg_err(cfg_err3),
      .eval_valid(eval_valid3), .eval_in(eval_in3), .eval_ready(eval_ready3),
      .sweep_start(sweep_start3), .sweep_busy(sweep_busy3), .sweep_done(sweep_done3),
      .sweep_ones(sweep_ones3), .out_valid(out_valid3), .out_idx(out_idx3), .out_y(out_y3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference function: sum of minterms 4,5,6,7,11,12,13.
   task automatic ref_reset();
      for (int m = 0; m < 16; m++) begin
         ref_tab[m] = (m inside {4, 5, 6, 7, 11, 12, 13});
      end
   endtask

   task automatic do_sweep(input int werr_k, input int ev_code);
      int ones;
      ones = 0;
      for (int m = 0; m < 16; m++) ones += int'(ref_tab[m]);
      sweep_start = 1'b1;
      if (ev_code >= 0) begin
         eval_valid = 1'b1;
         eval_in    = ev_code[3:0];
      end
      tick();
      sweep_start = 1'b0;
      eval_valid  = 1'b0;
      if (ev_code >= 0) begin
         chk("sw_eval_valid", out_valid, 1);
         chk("sw_eval_idx", out_idx, ev_code);
         chk("sw_eval_y", out_y, ref_tab[ev_code]);
      end
      chk("sw_busy", sweep_busy, 1);
      chk("sw_ready", eval_ready, 0);
      for (int k = 0; k < 16; k++) begin
         if (k == werr_k) begin
            cfg_we   = 1'b1;
            cfg_addr = 4'd11;
            cfg_data = 1'b0;
         end
         tick();
         cfg_we = 1'b0;
         chk("sw_valid", out_valid, 1);
         chk("sw_idx", out_idx, k);
         chk("sw_y", out_y, ref_tab[k]);
         chk("sw_done_early", sweep_done, 0);
         if (werr_k >= 0 && (k == werr_k || k == werr_k + 1))
            chk("cfg_err", cfg_err, (k == werr_k));
      end
      tick();
      chk("sw_done", sweep_done, 1);
      chk("sw_ones", sweep_ones, ones);
      chk("sw_busy_done", sweep_busy, 1);
      chk("sw_ready_done", eval_ready, 0);
      chk("sw_valid_drain", out_valid, 0);
      tick();
      chk("sw_done_pulse", sweep_done, 0);
      chk("sw_ready_idle", eval_ready, 1);
      chk("sw_busy_idle", sweep_busy, 0);
      chk("sw_ones_hold", sweep_ones, ones);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int ev, wr, code, addr, dat, exp_ones3;
      rst_n = 1'b0;
      {cfg_we, cfg_addr, cfg_data, eval_valid, eval_in, sweep_start} = '0;
      {cfg_we3, cfg_addr3, cfg_data3, eval_valid3, eval_in3, sweep_start3} = '0;
      ref_reset();
      #13;
      chk("rst_valid", out_valid, 0);
      chk("rst_y", out_y, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_busy", sweep_busy, 0);
      chk("rst_done", sweep_done, 0);
      chk("rst_ones", sweep_ones, 0);
      chk("rst_ready", eval_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      do_sweep(-1, -1);

      for (int i = 0; i < 16; i++) begin
         eval_valid = 1'b1;
         eval_in    = 4'(i);
         tick();
         chk("ev_valid", out_valid, 1);
         chk("ev_idx", out_idx, i);
         chk("ev_y", out_y, ref_tab[i]);
      end
      eval_valid = 1'b0;
      tick();
      chk("ev_idle_valid", out_valid, 0);

      // write and evaluate the same address in one cycle
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 1'b1;
      eval_valid = 1'b1; eval_in = 4'd0;
      tick();
      cfg_we = 1'b0;
      chk("wr_old_y", out_y, 0);
      ref_tab[0] = 1'b1;
      tick();
      eval_valid = 1'b0;
      chk("wr_new_y", out_y, 1);
      tick();
      do_sweep(-1, -1);

      // reset in the middle of a sweep (index 9)
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_y", out_y, 0);
      chk("mrst_idx", out_idx, 0);
      chk("mrst_busy", sweep_busy, 0);
      chk("mrst_ones", sweep_ones, 0);
      chk("mrst_ready", eval_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      ref_reset();
      eval_valid = 1'b1; eval_in = 4'd0;
      tick();
      eval_valid = 1'b0;
      chk("mrst_eval0", out_y, 0);
      chk("mrst_eval0_v", out_valid, 1);

      do_sweep(5, -1);

      // random evaluates and writes in IDLE
      for (int n = 0; n < 80; n++) begin
         ev   = int'($urandom_range(0, 1));
         wr   = ($urandom_range(0, 3) == 0) ? 1 : 0;
         code = int'($urandom_range(0, 15));
         addr = int'($urandom_range(0, 15));
         dat  = int'($urandom_range(0, 1));
         eval_valid = ev[0]; eval_in = code[3:0];
         cfg_we = wr[0]; cfg_addr = addr[3:0]; cfg_data = dat[0:0];
         tick();
         chk("rnd_valid", out_valid, ev);
         if (ev != 0) begin
            chk("rnd_idx", out_idx, code);
            chk("rnd_y", out_y, ref_tab[code]);
         end
         chk("rnd_err", cfg_err, 0);
         if (wr != 0) ref_tab[addr] = dat[0];
      end
      eval_valid = 1'b0; cfg_we = 1'b0;
      do_sweep(-1, int'($urandom_range(0, 15)));

      // N_IN=3, N_OUT=2: y0 = parity of code, y1 = code < 4
      exp_ones3 = 0;
      sweep_start3 = 1'b1;
      tick();
      sweep_start3 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("s3_valid", out_valid3, 1);
         chk("s3_idx", out_idx3, k);
         chk("s3_y", out_y3, {(k < 4) ? 1'b1 : 1'b0, ^k[2:0]});
         exp_ones3 += int'(^k[2:0]);
      end
      tick();
      chk("s3_done", sweep_done3, 1);
      chk("s3_ones", sweep_ones3, exp_ones3);
      tick();
      chk("s3_ready", eval_ready3, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
